uart_rx: RTL and testbench

Serial receiver for the UART link; the consumer of the transmitter's `TX_OUT` line. It oversamples `RX_IN` by `PRESCALE` clocks per bit and majority-votes three mid-bit samples. It reassembles a frame of one start bit, 8 data bits sent LSB first, an optional parity bit and one stop bit. It presents the byte on `P_DATA` with a one-cycle `DATA_VALID` strobe and reports parity and stop (framing) errors.

---
 rtl/uart_rx.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART serial receiver. RX_IN is oversampled PRESCALE clocks per bit; three
// samples around the middle of each bit are majority-voted. A frame is one
// start bit (low), DATA_WIDTH data bits LSB first, an optional parity bit and
// one stop bit (high).
//
// Output handshake: there is no ready/backpressure. DATA_VALID, PAR_ERR and
// STP_ERR are single-cycle strobes, mutually exclusive, raised on the clock
// edge that ends the stop bit. P_DATA only changes together with DATA_VALID
// and holds its value otherwise; the consumer must take it on the strobe or
// later, before the next valid frame.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-high reset
//   RX_IN      serial line, idles high, asynchronous to CLK
//   PAR_EN     1 = frame carries a parity bit (latched at frame start)
//   PAR_TYP    0 = even, 1 = odd parity (latched at frame start)
//   P_DATA     last correctly received byte
//   DATA_VALID one-cycle strobe: P_DATA updated
//   PAR_ERR    one-cycle strobe: parity mismatch
//   STP_ERR    one-cycle strobe: stop bit sampled low
//   state_dbg  current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic [2:0]            state_dbg
);

    localparam int CW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] SAMP_0   = CW'(PRESCALE / 2 - 2);
    localparam logic [CW-1:0] SAMP_1   = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] SAMP_2   = CW'(PRESCALE / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              sync_q;
    logic                    rx_s;
    logic [CW-1:0]           edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [1:0]              samp_q;
    logic                    bit_q;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    par_flag_q;
    logic                    cnt_last;
    logic                    frame_start;
    logic                    dv_d;
    logic                    pe_d;
    logic                    se_d;

    assign rx_s      = sync_q[1];
    assign cnt_last  = (edge_cnt == CNT_LAST);
    assign state_dbg = state_q;

    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and end-of-frame outcome. Stop error outranks parity error.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        dv_d        = 1'b0;
        pe_d        = 1'b0;
        se_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d     = START;
                    frame_start = 1'b1;
                end
            end
            START: begin
                if (cnt_last) begin
                    // A start bit that votes high was a glitch.
                    state_d = bit_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_last && (bit_cnt == BIT_LAST)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    if (!bit_q) begin
                        se_d = 1'b1;
                    end else if (par_flag_q) begin
                        pe_d = 1'b1;
                    end else begin
                        dv_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Oversampling counter: held at 0 in IDLE, free-running and wrapping in
    // every other state so each state lasts a whole number of bit times.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
        end else if (state_q == IDLE) begin
            edge_cnt <= '0;
        end else if (cnt_last) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    // Mid-bit sampling; the vote is registered together with the third sample
    // and stays stable until the next bit's vote.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_q <= 2'b11;
            bit_q  <= 1'b1;
        end else if (state_q != IDLE) begin
            if (edge_cnt == SAMP_0) begin
                samp_q[0] <= rx_s;
            end
            if (edge_cnt == SAMP_1) begin
                samp_q[1] <= rx_s;
            end
            if (edge_cnt == SAMP_2) begin
                bit_q <= (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
            end
        end
    end

    // Frame datapath: config latch, data shift register, bit counter, parity.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
        end else begin
            if (frame_start) begin
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                par_flag_q <= 1'b0;
                bit_cnt    <= '0;
            end
            if ((state_q == DATA) && cnt_last) begin
                // LSB arrives first, so shift right and insert at the MSB.
                shreg   <= {bit_q, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end
            if ((state_q == PARITY) && cnt_last) begin
                // Expected bit is XOR of data, inverted for odd parity.
                par_flag_q <= bit_q ^ (^shreg) ^ par_typ_q;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= dv_d;
            PAR_ERR    <= pe_d;
            STP_ERR    <= se_d;
            if (dv_d) begin
                P_DATA <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Two receivers (PRESCALE 8 and 16) share clock, reset and parity config.
// The driver serialises frames onto each line and, at the same time, pushes
// the expected outcome {kind, P_DATA, strobe cycle} into a per-instance queue.
// The expected strobe cycle comes from the frame-length rule: the receiver
// starts 2 edges after the line falls (or 1 edge after it last went idle,
// whichever is later) and strobes N*PRESCALE edges after that.
// A negedge monitor pops and compares whenever a strobe is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_PAR   = 2'd1;
  localparam logic [1:0] K_STP   = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, rx16;
  logic       par_en, par_typ;
  logic [7:0] pd8, pd16;
  logic       dv8, pe8, se8, dv16, pe16, se16;
  logic [2:0] st8, st16;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // {kind[41:40], p_data[39:32], strobe_cycle[31:0]}
  logic [41:0] exp_q8[$];
  logic [41:0] exp_q16[$];
  int          busy8 = 0;
  int          busy16 = 0;
  logic [7:0]  model8 = 8'h00;
  logic [7:0]  model16 = 8'h00;

  uart_rx #(.PRESCALE(8), .DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .RX_IN(rx8), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .P_DATA(pd8), .DATA_VALID(dv8), .PAR_ERR(pe8), .STP_ERR(se8), .state_dbg(st8)
  );

  uart_rx #(.PRESCALE(16), .DATA_WIDTH(8)) dut16 (
    .CLK(clk), .RST(rst), .RX_IN(rx16), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .P_DATA(pd16), .DATA_VALID(dv16), .PAR_ERR(pe16), .STP_ERR(se16), .state_dbg(st16)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int inst, input logic dv, input logic pe, input logic se,
                     input logic [7:0] pd);
    logic [41:0] e;
    logic        found;
    logic [1:0]  kind;
    if (dv | pe | se) begin
      check($sformatf("strobe_exclusive_%0d", inst), {31'd0, ($countones({dv, pe, se}) == 1)}, 32'd1);
      found = 1'b0;
      e = '0;
      if (inst == 0 && exp_q8.size() > 0) begin
        e = exp_q8.pop_front();
        found = 1'b1;
      end else if (inst == 1 && exp_q16.size() > 0) begin
        e = exp_q16.pop_front();
        found = 1'b1;
      end
      if (!found) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe_%0d: got dv=%0b pe=%0b se=%0b expected none (cycle %0d)",
                 inst, dv, pe, se, cyc);
      end else begin
        kind = dv ? K_VALID : (pe ? K_PAR : K_STP);
        check($sformatf("strobe_kind_%0d", inst), {30'd0, kind}, {30'd0, e[41:40]});
        check($sformatf("strobe_cycle_%0d", inst), cyc, e[31:0]);
        check($sformatf("p_data_%0d", inst), {24'd0, pd}, {24'd0, e[39:32]});
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, dv8, pe8, se8, pd8);
    mon(1, dv16, pe16, se16, pd16);
  end

  // ---------------------------------------------------------------- drivers
  task automatic set_line(input int inst, input logic v);
    if (inst == 0) rx8 = v;
    else rx16 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge. par_flip inverts the correct parity bit; stop_bit is
  // the value driven in the stop slot; spike_bit is a frame bit index whose
  // middle gets a one-cycle inverted spike (-1 for none).
  task automatic send_frame(input int inst, input logic [7:0] data, input logic pen,
                            input logic ptyp, input logic par_flip, input logic stop_bit,
                            input int spike_bit);
    int p, n, e1, k, fin, busy;
    logic [10:0] fr;
    logic        pbit;
    logic [1:0]  kind;
    logic [7:0]  model;
    p = (inst == 0) ? 8 : 16;
    par_en  = pen;
    par_typ = ptyp;
    pbit = (^data) ^ ptyp ^ par_flip;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = data;
    if (pen) begin
      fr[9]  = pbit;
      fr[10] = stop_bit;
      n = 11;
    end else begin
      fr[9] = stop_bit;
      n = 10;
    end
    e1   = cyc + 1;
    busy = (inst == 0) ? busy8 : busy16;
    k    = (e1 + 2 > busy + 1) ? e1 + 2 : busy + 1;
    fin  = k + n * p;
    model = (inst == 0) ? model8 : model16;
    if (!stop_bit) kind = K_STP;
    else if (pen && par_flip) kind = K_PAR;
    else begin
      kind  = K_VALID;
      model = data;
    end
    if (inst == 0) begin
      busy8 = fin;
      model8 = model;
      exp_q8.push_back({kind, model, fin[31:0]});
    end else begin
      busy16 = fin;
      model16 = model;
      exp_q16.push_back({kind, model, fin[31:0]});
    end
    for (int b = 0; b < n; b++) begin
      set_line(inst, fr[b]);
      for (int c = 0; c < p; c++) begin
        if (b == spike_bit && c == p / 2 - 1) set_line(inst, ~fr[b]);
        if (b == spike_bit && c == p / 2) set_line(inst, fr[b]);
        @(negedge clk);
      end
    end
    set_line(inst, 1'b1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int e1;
    int t;
    logic [7:0] abort_byte;
    rst = 1'b1;
    rx8 = 1'b1;
    rx16 = 1'b1;
    par_en = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_p_data", {24'd0, pd8}, 32'd0);
    check("reset_strobes", {29'd0, dv8, pe8, se8}, 32'd0);
    check("reset_p_data16", {24'd0, pd16}, 32'd0);
    check("reset_state", {29'd0, st8}, 32'd0);
    rst = 1'b0;
    idle(5);

    // 8N1 clean frame
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    // Parity: even with wrong bit -> PAR_ERR, P_DATA stays 0xA5
    send_frame(0, 8'h65, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    idle(10);
    // Parity: even and odd with correct bits
    send_frame(0, 8'h65, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    send_frame(0, 8'h65, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    idle(10);
    // Framing error followed by a good frame
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(10);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);

    // Two-cycle glitch: receiver enters START, votes high, returns to IDLE
    e1 = cyc + 1;
    rx8 = 1'b0;
    idle(2);
    rx8 = 1'b1;
    busy8 = e1 + 2 + 8;
    idle(20);
    check("idle_after_glitch", {29'd0, st8}, 32'd0);

    // Single-cycle spike at a sample point inside data bit 3
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    idle(10);
    // Spike inside the parity bit of a parity frame
    send_frame(0, 8'h37, 1'b1, 1'b1, 1'b0, 1'b1, 9);
    idle(10);

    // Back-to-back, no idle gap
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);

    // Reset in the middle of DATA: no strobe, outputs cleared at once
    abort_byte = 8'h96;
    rx8 = 1'b0;
    idle(8);
    for (int b = 0; b < 4; b++) begin
      rx8 = abort_byte[b];
      idle(8);
    end
    rst = 1'b1;
    #1;
    check("midframe_rst_p_data", {24'd0, pd8}, 32'd0);
    check("midframe_rst_strobes", {29'd0, dv8, pe8, se8}, 32'd0);
    check("midframe_rst_state", {29'd0, st8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rx8 = 1'b1;
    busy8 = 0;
    busy16 = 0;
    model8 = 8'h00;
    model16 = 8'h00;
    idle(10);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);

    // Transmitter-style frames at PRESCALE 16
    send_frame(1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    idle(10);
    send_frame(1, 8'hE7, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(10);
    send_frame(1, 8'h42, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    idle(10);

    // Randomised frames
    for (int i = 0; i < 24; i++) begin
      int inst;
      int spike;
      inst  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      spike = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1;
      send_frame(inst, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) != 0), spike);
      idle($urandom_range(2, 20));
    end

    // Drain with a bounded wait
    t = 0;
    while ((exp_q8.size() + exp_q16.size()) != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("queues_drained", exp_q8.size() + exp_q16.size(), 32'd0);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
